// File: rtl/dice_roll_engine.sv
// Multi-die roller: rejection-samples the SIPO stream into 1..MAX_DICE uniform dice,
// accumulates the sum and optionally sends it as two 8N1 UART bytes (low byte first).
module dice_roll_engine #(
  parameter int RAND_W       = 7,
  parameter int MAX_DICE     = 8,
  parameter int SUM_W        = 10,
  parameter int UART_EN      = 1,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_roll,
  input  logic [3:0]        i_dieSelect,
  input  logic [3:0]        i_count,
  input  logic [RAND_W-1:0] i_randomData,
  input  logic              i_valid,
  output logic              o_req,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [SUM_W-1:0]  o_sum,
  output logic [6:0]        o_lastDie,
  output logic [7:0]        o_rejects,
  output logic              o_tx
);

  typedef enum logic [2:0] {
    IDLE, COLLECT, DONE, TX_START, TX_DATA, TX_STOP
  } state_t;

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);

  state_t           r_state, w_next;
  logic [6:0]       r_sides, r_mask, r_lastDie;
  logic [3:0]       r_remaining;
  logic [SUM_W-1:0] r_acc, r_sum;
  logic [7:0]       r_rejects, r_shift;
  logic             r_err, r_byteIdx;
  logic [2:0]       r_bitCnt;
  logic [CNT_W-1:0] r_clkCnt;

  logic [6:0]       w_sides, w_mask, w_m;
  logic             w_selValid, w_cntValid, w_start, w_accept, w_reject, w_final, w_tick, w_inTx;
  logic [SUM_W-1:0] w_accNext;
  logic [15:0]      w_sum16;

  // Masking to k=clog2(sides) bits keeps the rejection rate below one half.
  always_comb begin
    w_sides    = '0;
    w_mask     = '0;
    w_selValid = 1'b1;
    case (i_dieSelect)
      4'd0:    begin w_sides = 7'd2;   w_mask = 7'h01; end
      4'd1:    begin w_sides = 7'd4;   w_mask = 7'h03; end
      4'd2:    begin w_sides = 7'd6;   w_mask = 7'h07; end
      4'd3:    begin w_sides = 7'd8;   w_mask = 7'h07; end
      4'd4:    begin w_sides = 7'd10;  w_mask = 7'h0F; end
      4'd5:    begin w_sides = 7'd20;  w_mask = 7'h1F; end
      4'd6:    begin w_sides = 7'd100; w_mask = 7'h7F; end
      default: w_selValid = 1'b0;
    endcase
  end

  assign w_cntValid = (i_count != 4'd0) && (i_count <= 4'(MAX_DICE));
  assign w_start    = (r_state == IDLE) && i_roll && w_selValid && w_cntValid;
  assign w_m        = i_randomData[6:0] & r_mask;
  assign w_accept   = (r_state == COLLECT) && i_valid && (w_m < r_sides);
  assign w_reject   = (r_state == COLLECT) && i_valid && !(w_m < r_sides);
  assign w_final    = w_accept && (r_remaining == 4'd1);
  assign w_accNext  = r_acc + SUM_W'(w_m) + SUM_W'(1);
  assign w_sum16    = 16'(r_sum);
  assign w_tick     = (r_clkCnt == LAST_CLK);
  assign w_inTx     = (r_state == TX_START) || (r_state == TX_DATA) || (r_state == TX_STOP);

  always_comb begin
    w_next = r_state;
    o_req  = 1'b0;
    o_busy = 1'b1;
    o_done = 1'b0;
    o_tx   = 1'b1;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (w_start) w_next = COLLECT;
      end
      COLLECT: begin
        o_req = 1'b1;
        if (w_final) w_next = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        w_next = (UART_EN != 0) ? TX_START : IDLE;
      end
      TX_START: begin
        o_tx = 1'b0;
        if (w_tick) w_next = TX_DATA;
      end
      TX_DATA: begin
        o_tx = r_shift[0];
        if (w_tick && (r_bitCnt == 3'd7)) w_next = TX_STOP;
      end
      TX_STOP: begin
        if (w_tick) w_next = r_byteIdx ? IDLE : TX_START;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_sides     <= '0;
      r_mask      <= '0;
      r_lastDie   <= '0;
      r_remaining <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_rejects   <= '0;
      r_shift     <= '0;
      r_err       <= 1'b0;
      r_byteIdx   <= 1'b0;
      r_bitCnt    <= '0;
      r_clkCnt    <= '0;
    end else begin
      r_state  <= w_next;
      r_err    <= (r_state == IDLE) && i_roll && !(w_selValid && w_cntValid);
      r_clkCnt <= (w_inTx && !w_tick) ? r_clkCnt + CNT_W'(1) : '0;
      case (r_state)
        IDLE: if (w_start) begin
          r_sides     <= w_sides;
          r_mask      <= w_mask;
          r_remaining <= i_count;
          r_acc       <= '0;
          r_rejects   <= '0;
        end
        COLLECT: begin
          // Sum is published on the final accept so it is valid alongside o_done.
          if (w_accept) begin
            r_acc       <= w_accNext;
            r_lastDie   <= w_m + 7'd1;
            r_remaining <= r_remaining - 4'd1;
            if (w_final) r_sum <= w_accNext;
          end
          if (w_reject && (r_rejects != 8'hFF)) r_rejects <= r_rejects + 8'd1;
        end
        DONE: begin
          r_byteIdx <= 1'b0;
          r_shift   <= w_sum16[7:0];
        end
        TX_START: if (w_tick) r_bitCnt <= '0;
        TX_DATA: if (w_tick) begin
          r_shift  <= r_shift >> 1;
          r_bitCnt <= r_bitCnt + 3'd1;
        end
        TX_STOP: if (w_tick) begin
          r_byteIdx <= 1'b1;
          r_shift   <= w_sum16[15:8];
        end
        default: ;
      endcase
    end
  end

  assign o_err     = r_err;
  assign o_sum     = r_sum;
  assign o_lastDie = r_lastDie;
  assign o_rejects = r_rejects;

endmodule

// File: tb/tb_dice_roll_engine.sv
// Randomised bench for dice_roll_engine against a queue-driven dice model and a
// bit-timed UART frame model.
module tb_dice_roll_engine;

  localparam int CLKS = 8;
  localparam int MAXD = 8;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0, i_roll = 1'b0, i_valid = 1'b0;
  logic [3:0] i_dieSelect = '0, i_count = '0;
  logic [6:0] i_randomData = '0;
  logic       o_req, o_busy, o_done, o_err, o_tx;
  logic [9:0] o_sum;
  logic [6:0] o_lastDie;
  logic [7:0] o_rejects;

  int n_vec = 0;
  int n_err = 0;
  int e_sum = 0, e_last = 0, e_rej = 0;
  int q_samp[$];
  int side_tab[7] = '{2, 4, 6, 8, 10, 20, 100};

  always #5 clk = ~clk;

  dice_roll_engine #(
    .RAND_W(7), .MAX_DICE(MAXD), .SUM_W(10), .UART_EN(1), .CLKS_PER_BIT(CLKS)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_roll(i_roll), .i_dieSelect(i_dieSelect),
    .i_count(i_count), .i_randomData(i_randomData), .i_valid(i_valid),
    .o_req(o_req), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_sum(o_sum), .o_lastDie(o_lastDie), .o_rejects(o_rejects), .o_tx(o_tx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_req"}, o_req, 0);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_done"}, o_done, 0);
    check_eq({tag, "_tx"}, o_tx, 1);
  endtask

  // Rolls sel/cnt; samples come from q_samp first, then $urandom with random gaps.
  // tx_cycles: number of cycles of the UART frame to check (20*CLKS = whole frame).
  task automatic roll(input int sel, input int cnt, input int tx_cycles);
    int sides, k, remaining, m, byte_idx, bit_idx, pos, exp_bit;
    logic [6:0] s;
    logic [7:0] bval;
    sides = side_tab[sel];
    k = 0;
    while ((1 << k) < sides) k++;
    i_dieSelect = 4'(sel);
    i_count = 4'(cnt);
    i_roll = 1'b1;
    tick();
    i_roll = 1'b0;
    check_eq("start_req", o_req, 1);
    check_eq("start_busy", o_busy, 1);
    remaining = cnt;
    e_sum = 0;
    e_rej = 0;
    while (remaining > 0) begin
      if (q_samp.size() > 0) begin
        s = 7'(q_samp.pop_front());
        i_valid = 1'b1;
      end else begin
        s = 7'($urandom);
        i_valid = ($urandom_range(0, 3) != 0);
      end
      i_randomData = s;
      i_roll = ($urandom_range(0, 4) == 0);
      i_dieSelect = 4'($urandom);
      i_count = 4'($urandom);
      tick();
      if (i_valid) begin
        m = int'(s) % (1 << k);
        if (m < sides) begin
          e_sum += m + 1;
          e_last = m + 1;
          remaining--;
        end else if (e_rej < 255) begin
          e_rej++;
        end
      end
      if (remaining > 0) begin
        check_eq("req_hold", o_req, 1);
        check_eq("no_early_done", o_done, 0);
        check_eq("no_err_busy", o_err, 0);
      end
    end
    i_valid = 1'b0;
    i_roll = 1'b0;
    check_eq("done_pulse", o_done, 1);
    check_eq("done_req_low", o_req, 0);
    check_eq("sum", o_sum, 32'(e_sum));
    check_eq("last_die", o_lastDie, 32'(e_last));
    check_eq("rejects", o_rejects, 32'(e_rej));
    for (int j = 0; j < tx_cycles; j++) begin
      i_roll = ($urandom_range(0, 7) == 0);
      tick();
      byte_idx = j / (10 * CLKS);
      pos = j % (10 * CLKS);
      bit_idx = pos / CLKS;
      bval = 8'((byte_idx == 0) ? e_sum : (e_sum >> 8));
      if (bit_idx == 0) exp_bit = 0;
      else if (bit_idx == 9) exp_bit = 1;
      else exp_bit = int'(bval[bit_idx-1]);
      check_eq("tx_bit", o_tx, 32'(exp_bit));
      check_eq("tx_busy", o_busy, 1);
      check_eq("tx_no_done", o_done, 0);
      check_eq("tx_no_err", o_err, 0);
    end
    if (tx_cycles == 20 * CLKS) begin
      tick();
      i_roll = 1'b0;
      check_idle("after_tx");
      check_eq("held_sum", o_sum, 32'(e_sum));
    end
    i_roll = 1'b0;
  endtask

  task automatic bad_roll(input int sel, input int cnt, input string tag);
    i_dieSelect = 4'(sel);
    i_count = 4'(cnt);
    i_roll = 1'b1;
    tick();
    i_roll = 1'b0;
    check_eq({tag, "_err"}, o_err, 1);
    check_eq({tag, "_busy"}, o_busy, 0);
    tick();
    check_eq({tag, "_err_clr"}, o_err, 0);
    check_eq({tag, "_busy2"}, o_busy, 0);
    check_eq({tag, "_sum"}, o_sum, 32'(e_sum));
  endtask

  initial begin
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    check_idle("reset");
    check_eq("reset_err", o_err, 0);
    check_eq("reset_sum", o_sum, 0);
    check_eq("reset_last", o_lastDie, 0);
    check_eq("reset_rej", o_rejects, 0);

    q_samp = '{7'b0010011};
    roll(5, 1, 20 * CLKS);

    q_samp = '{6, 7, 2};
    roll(2, 1, 20 * CLKS);

    q_samp = '{99, 99, 99, 99, 99, 99, 99, 99};
    roll(6, 8, 20 * CLKS);

    bad_roll(9, 1, "bad_sel");
    bad_roll(2, 0, "zero_cnt");
    bad_roll(1, MAXD + 1, "big_cnt");
    bad_roll(15, 3, "sel15");

    for (int j = 0; j < 5; j++) begin
      i_valid = 1'b1;
      i_randomData = 7'($urandom);
      tick();
      check_idle("idle_valid");
      check_eq("idle_valid_rej", o_rejects, 32'(e_rej));
    end
    i_valid = 1'b0;

    for (int r = 0; r < 12; r++)
      roll($urandom_range(0, 6), $urandom_range(1, MAXD), 20 * CLKS);
    roll(0, MAXD, 20 * CLKS);
    roll(3, 1, 20 * CLKS);

    i_dieSelect = 4'd1;
    i_count = 4'd4;
    i_roll = 1'b1;
    tick();
    i_roll = 1'b0;
    i_valid = 1'b1;
    i_randomData = 7'd0;
    tick();
    i_randomData = 7'd3;
    tick();
    i_valid = 1'b0;
    check_eq("mid_req", o_req, 1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_idle("rst_collect");
    check_eq("rst_collect_sum", o_sum, 0);
    check_eq("rst_collect_last", o_lastDie, 0);
    tick();
    check_idle("rst_collect2");

    roll(4, 2, 4 * CLKS + 3);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_idle("rst_tx");
    tick();
    check_idle("rst_tx2");

    roll(1, 4, 20 * CLKS);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dice_roll_engine.md
Name: dice_roll_engine

Overview:
Parametrised successor to the single-die post-processor. Rolls 1..MAX_DICE dice of a selected type using the SIPO random stream and rejection sampling for exact uniformity, then accumulates the sum. Optionally serialises the 16-bit sum over a UART 8N1 transmitter. It sits between the SIPO random source and the display/UART path, and gates the SIPO through o_req.

Parameters:
RAND_W, 7, width of i_randomData; must be ≥7 so d100 is reachable.
MAX_DICE, 8, maximum dice per roll; legal range 1..15.
SUM_W, 10, width of o_sum; must hold MAX_DICE*100 and be ≤16.
UART_EN, 1, 1 = transmit the sum after each roll; 0 = no transmission, o_tx held at 1.
CLKS_PER_BIT, 868, number of i_clk cycles per UART bit.

Ports:
i_clk  in  1  system clock, rising edge.
i_reset  in  1  synchronous reset, active-high.
i_roll  in  1  single-cycle start strobe.
i_dieSelect  in  4  die code: 0=d2, 1=d4, 2=d6, 3=d8, 4=d10, 5=d20, 6=d100; 7..15 are invalid.
i_count  in  4  number of dice; legal values 1..MAX_DICE.
i_randomData  in  RAND_W  random sample from the SIPO.
i_valid  in  1  i_randomData is valid this cycle.
o_req  out  1  random source enable; drives the SIPO i_start.
o_busy  out  1  roll or transmit is in progress.
o_done  out  1  one-cycle pulse when o_sum is updated.
o_err  out  1  one-cycle pulse when a start request is rejected.
o_sum  out  SUM_W  last completed sum; held until the next o_done.
o_lastDie  out  7  value of the most recently accepted die (1..sides).
o_rejects  out  8  samples rejected during the current/last roll; saturates at 255.
o_tx  out  1  UART serial output; idles high.

Behaviour:
- Reset (i_reset=1 at a rising edge): state=IDLE. o_req=0, o_busy=0, o_done=0, o_err=0, o_sum=0, o_lastDie=0, o_rejects=0, o_tx=1. Reset takes effect mid-roll or mid-transmit, aborting the operation with no o_done.
- States: IDLE, COLLECT, DONE, TX_START, TX_DATA, TX_STOP.
- IDLE:
  - i_roll=1 with a valid select and 1≤i_count≤MAX_DICE: latch sides and count; clear the accumulator and o_rejects; go to COLLECT next cycle.
  - i_roll=1 with an invalid select, i_count=0, or i_count>MAX_DICE: o_err=1 for exactly one cycle; state stays IDLE.
  - i_valid is ignored in IDLE.
- COLLECT: o_req=1, o_busy=1.
  - On i_valid, let k=clog2(sides) (1,2,3,3,4,5,7) and m = low k bits of i_randomData.
  - m<sides → accept: accumulator += m+1, o_lastDie=m+1, remaining -= 1.
  - m≥sides → reject: o_rejects += 1 (saturating at 255); remaining unchanged.
  - Accept with remaining becoming 0 → DONE next cycle.
  - o_req drops to 0 in the cycle after the final accept.
- DONE: o_sum=accumulator and o_done=1 for one cycle. Next state is TX_START if UART_EN=1, otherwise IDLE.
- TX: sends 2 bytes, low byte then {zero-padded upper bits}. Each byte is 8N1, LSB first: start bit 0, 8 data bits, stop bit 1, each held for CLKS_PER_BIT cycles. After the second stop bit → IDLE. o_busy=1 throughout TX.
- i_roll while o_busy=1 is ignored: no o_err, no restart.
- Latency: a roll with no rejections completes N valid samples plus 1 cycle after the start. o_done is asserted in the cycle following the cycle of the last accepted sample.
- i_dieSelect and i_count may change freely after the start cycle without affecting the current roll.
- Sum bound: MAX_DICE*100 < 2^SUM_W, so the accumulator never overflows.

Test Plan:
1. Reset held 2 cycles → all outputs at reset values, o_tx=1; then i_roll with select=5 (d20), count=1, and i_randomData=7'b0010011 (m=19) → accepted; o_sum=20 and o_lastDie=20 with o_done one cycle later; o_rejects=0.
2. d6, count=1, samples m=6, 7, 2 → two rejects, then accept; o_rejects=2, o_sum=3, o_req high only until the accept.
3. d100, count=8, eight samples of 99 → o_sum=800 with no overflow; with UART_EN=1, o_tx sends 0x20 then 0x03, each bit lasting exactly CLKS_PER_BIT cycles.
4. i_roll with select=9, or with count=0 → o_err pulses exactly 1 cycle, o_busy stays 0, o_sum unchanged.
5. i_roll re-asserted during COLLECT, and i_valid pulsed during IDLE → both ignored; o_sum from the original roll is correct.
6. i_reset asserted mid-COLLECT (count=4, 2 dice accepted) and mid-TX_DATA → IDLE next cycle, o_req=0, o_tx=1, no o_done; a new d4 roll afterwards completes normally.
